// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front end: deserialises frames, decodes E0/F0/E1 prefixes, tracks held keys, queues make/break events.
// Optional auto-repeat generation is enabled by defining KBD_AUTOREPEAT_EN.
module ps2_key_tracker #(
  parameter int FIFO_DEPTH    = 8,
  parameter int TIMEOUT_CYC   = 100000,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [2:0] key,
  output logic [7:0] held,
  output logic       ev_valid,
  output logic [3:0] ev_code,
  input  logic       ev_ready,
  output logic       ev_overflow,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYC < 2 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("ps2_key_tracker: illegal parameter value");
  end

  typedef enum logic [1:0] {R_IDLE, R_DATA, R_PARITY, R_STOP} rx_state_t;
  typedef enum logic [1:0] {P_BASE, P_EXT, P_BRK, P_EXT_BRK} ps_state_t;

  // Synchronisers; clock chain resets high so a released line never looks like a fall
  logic [2:0] clk_sync;
  logic [1:0] dat_sync;
  logic       fall;
  logic       din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= 3'b111;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  assign fall = clk_sync[2] & ~clk_sync[1];
  assign din  = dat_sync[1];

  rx_state_t       rx_state, rx_nxt;
  logic [7:0]      shift, shift_nxt;
  logic [2:0]      bit_cnt, bit_cnt_nxt;
  logic            par_ok, par_ok_nxt;
  logic [TW-1:0]   wd_cnt, wd_nxt;
  logic            byte_vld, byte_vld_nxt;
  logic            err_nxt;

  always_comb begin
    rx_nxt       = rx_state;
    shift_nxt    = shift;
    bit_cnt_nxt  = bit_cnt;
    par_ok_nxt   = par_ok;
    wd_nxt       = wd_cnt;
    byte_vld_nxt = 1'b0;
    err_nxt      = 1'b0;
    if (fall) begin
      wd_nxt = '0;
      case (rx_state)
        R_IDLE: begin
          if (!din) begin
            rx_nxt      = R_DATA;
            bit_cnt_nxt = 3'd0;
          end
        end
        R_DATA: begin
          shift_nxt   = {din, shift[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) rx_nxt = R_PARITY;
        end
        R_PARITY: begin
          par_ok_nxt = ^{shift, din};
          rx_nxt     = R_STOP;
        end
        default: begin
          if (din && par_ok) byte_vld_nxt = 1'b1;
          else               err_nxt      = 1'b1;
          rx_nxt = R_IDLE;
        end
      endcase
    end else if (rx_state != R_IDLE) begin
      if (wd_cnt == TW'(TIMEOUT_CYC - 1)) begin
        rx_nxt = R_IDLE;
        wd_nxt = '0;
      end else begin
        wd_nxt = wd_cnt + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state  <= R_IDLE;
      shift     <= '0;
      bit_cnt   <= '0;
      par_ok    <= 1'b0;
      wd_cnt    <= '0;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_state  <= rx_nxt;
      shift     <= shift_nxt;
      bit_cnt   <= bit_cnt_nxt;
      par_ok    <= par_ok_nxt;
      wd_cnt    <= wd_nxt;
      byte_vld  <= byte_vld_nxt;
      frame_err <= err_nxt;
    end
  end

  function automatic logic [2:0] map_code(input logic [7:0] b, input logic ext);
    logic [2:0] c;
    c = 3'd7;
    if (ext) begin
      case (b)
        8'h75: c = 3'd3;
        8'h72: c = 3'd4;
        8'h6B: c = 3'd5;
        8'h74: c = 3'd6;
        default: c = 3'd7;
      endcase
    end else begin
      case (b)
        8'h76:        c = 3'd1;
        8'h29:        c = 3'd2;
        8'h1D, 8'h42: c = 3'd3;
        8'h1B, 8'h3B: c = 3'd4;
        8'h1C, 8'h33: c = 3'd5;
        8'h23, 8'h4B: c = 3'd6;
        default:      c = 3'd7;
      endcase
    end
    return c;
  endfunction

  function automatic logic [2:0] lowest_held(input logic [7:0] h);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 1; i--) begin
      if (h[i]) r = 3'(i);
    end
    return r;
  endfunction

  ps_state_t  ps_state, ps_nxt;
  logic [2:0] skip_cnt, skip_nxt;
  logic [7:0] held_nxt;
  logic [2:0] key_nxt;
  logic [2:0] code;
  logic       par_push;
  logic [3:0] par_dat;

  always_comb begin
    ps_nxt   = ps_state;
    skip_nxt = skip_cnt;
    held_nxt = held;
    key_nxt  = key;
    code     = 3'd0;
    par_push = 1'b0;
    par_dat  = 4'd0;
    if (byte_vld) begin
      if (skip_cnt != 3'd0) begin
        skip_nxt = skip_cnt - 3'd1;
      end else if (shift == 8'hE1) begin
        skip_nxt = 3'd7;
        ps_nxt   = P_BASE;
      end else if (shift == 8'hE0) begin
        ps_nxt = (ps_state == P_BRK || ps_state == P_EXT_BRK) ? P_EXT_BRK : P_EXT;
      end else if (shift == 8'hF0) begin
        ps_nxt = (ps_state == P_BASE || ps_state == P_BRK) ? P_BRK : P_EXT_BRK;
      end else begin
        code   = map_code(shift, ps_state == P_EXT || ps_state == P_EXT_BRK);
        ps_nxt = P_BASE;
        if (ps_state == P_BRK || ps_state == P_EXT_BRK) begin
          if (held[code]) begin
            held_nxt[code] = 1'b0;
            par_push       = 1'b1;
            par_dat        = {1'b0, code};
          end
          // Releasing the reported key falls back to the lowest still-held code
          if (code == key) key_nxt = lowest_held(held_nxt);
        end else begin
          if (!held[code]) begin
            held_nxt[code] = 1'b1;
            par_push       = 1'b1;
            par_dat        = {1'b1, code};
          end
          key_nxt = code;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_state <= P_BASE;
      skip_cnt <= '0;
      held     <= '0;
      key      <= '0;
    end else begin
      ps_state <= ps_nxt;
      skip_cnt <= skip_nxt;
      held     <= held_nxt;
      key      <= key_nxt;
    end
  end

  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, do_push, do_pop, push;
  logic [3:0]    push_dat;

  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);

`ifdef KBD_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_first, rep_fire;

  always_comb begin
    rep_fire = (key != 3'd0) && (key_nxt == key) && !full && !par_push &&
               (rep_cnt == (rep_first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (key_nxt != key) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (key == 3'd0 || full || par_push) begin
      rep_cnt <= rep_cnt;
    end else if (rep_fire) begin
      rep_cnt   <= '0;
      rep_first <= 1'b0;
    end else begin
      rep_cnt <= rep_cnt + RW'(1);
    end
  end

  assign push     = par_push | rep_fire;
  assign push_dat = par_push ? par_dat : {1'b1, key};
`else
  assign push     = par_push;
  assign push_dat = par_dat;
`endif

  assign do_pop  = ev_ready & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      ev_overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push && full && !do_pop) ev_overflow <= 1'b1;
    end
  end

  assign ev_valid = ~empty;
  assign ev_code  = mem[rd_ptr];

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: bit-banged PS/2 frames with hand-computed expectations.
module tb_ps2_key_tracker;
  localparam int DEPTH = 4;
  localparam int TMO   = 200;
  localparam int RDLY  = 3000;
  localparam int RPER  = 800;
  localparam int HALF  = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ev_ready = 1'b0;
  logic [2:0] key;
  logic [7:0] held;
  logic       ev_valid;
  logic [3:0] ev_code;
  logic       ev_overflow;
  logic       frame_err;

  int n_chk = 0;
  int n_pass = 0;
  int ferr_cnt = 0;

  ps2_key_tracker #(
    .FIFO_DEPTH   (DEPTH),
    .TIMEOUT_CYC  (TMO),
    .REPEAT_DELAY (RDLY),
    .REPEAT_PERIOD(RPER)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .key        (key),
    .held       (held),
    .ev_valid   (ev_valid),
    .ev_code    (ev_code),
    .ev_ready   (ev_ready),
    .ev_overflow(ev_overflow),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) ferr_cnt++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic ps2_bit(input logic v, input bit hold_low);
    ps2_data = v;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    if (!hold_low) begin
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  // hold_stop leaves ps2_clk low right after the stop-bit fall for cycle-exact checks
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit hold_stop);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(f[i], hold_stop && i == 10);
    if (!hold_stop) repeat (8) @(negedge clk);
  endtask

  task automatic release_clk();
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic pop_chk(input string tag, input logic [3:0] exp);
    chk({tag, "_vld"}, ev_valid, 1);
    chk({tag, "_code"}, ev_code, exp);
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_key", key, 0);
    chk("rst_held", held, 0);
    chk("rst_vld", ev_valid, 0);
    chk("rst_code", ev_code, 0);
    chk("rst_ovf", ev_overflow, 0);
    chk("rst_ferr", frame_err, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 0x1D up: nothing at N+1, everything at N+2
    send_frame(8'h1D, 0, 1);
    repeat (3) @(negedge clk);
    chk("lat_n1_held", held, 8'h00);
    chk("lat_n1_vld", ev_valid, 0);
    @(negedge clk);
    chk("lat_n2_held", held, 8'h08);
    chk("lat_n2_key", key, 3);
    chk("lat_n2_vld", ev_valid, 1);
    chk("lat_n2_code", ev_code, 4'hB);
    release_clk();
    pop_chk("pop_up", 4'hB);
    chk("empty_after_pop", ev_valid, 0);

    // Extended up make then break; up was already released? no: still held from 0x1D
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1D, 0, 0);
    pop_chk("brk_up", 4'h3);
    send_frame(8'hE0, 0, 0);
    send_frame(8'h75, 0, 0);
    chk("ext_up_held", held, 8'h08);
    chk("ext_up_key", key, 3);
    pop_chk("ext_up_make", 4'hB);
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    chk("ext_brk_held", held, 8'h00);
    chk("ext_brk_key", key, 0);
    pop_chk("ext_up_brk", 4'h3);
    chk("no_ferr", ferr_cnt, 0);

    // Bad parity on space
    send_frame(8'h29, 1, 1);
    repeat (3) @(negedge clk);
    chk("ferr_pulse", frame_err, 1);
    @(negedge clk);
    chk("ferr_one_cycle", frame_err, 0);
    release_clk();
    chk("ferr_held", held, 0);
    chk("ferr_key", key, 0);
    chk("ferr_vld", ev_valid, 0);
    chk("ferr_count", ferr_cnt, 1);

    // Fill the 4-deep FIFO, then overflow with a fifth make
    send_frame(8'h76, 0, 0);
    send_frame(8'h29, 0, 0);
    send_frame(8'h1D, 0, 0);
    send_frame(8'h1B, 0, 0);
    chk("ovf_at_4", ev_overflow, 0);
    send_frame(8'h1C, 0, 0);
    chk("ovf_at_5", ev_overflow, 1);
    chk("ovf_held", held, 8'h3E);
    chk("ovf_key", key, 5);

    // Break esc while full, popping on the push cycle
    send_frame(8'hF0, 0, 0);
    send_frame(8'h76, 0, 1);
    repeat (3) @(negedge clk);
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    release_clk();
    pop_chk("full_q0", 4'hA);
    pop_chk("full_q1", 4'hB);
    pop_chk("full_q2", 4'hC);
    pop_chk("full_q3", 4'h1);
    chk("full_drained", ev_valid, 0);
    chk("full_held", held, 8'h3C);
    chk("full_key", key, 5);

    // Releasing the reported key picks the lowest remaining held code
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);
    chk("fallback_key", key, 2);
    chk("fallback_held", held, 8'h1C);
    pop_chk("brk_left", 4'h5);

    // Abandoned frame recovered by the watchdog
    ps2_bit(1'b0, 0);
    ps2_bit(1'b1, 0);
    ps2_bit(1'b0, 0);
    ps2_bit(1'b1, 0);
    repeat (TMO + 20) @(negedge clk);
    send_frame(8'h76, 0, 0);
    chk("tmo_key", key, 1);
    chk("tmo_held", held, 8'h1E);
    chk("tmo_ferr", ferr_cnt, 1);
    pop_chk("tmo_esc", 4'h9);

    // Typematic repeat of a held key queues nothing
    send_frame(8'h76, 0, 0);
    chk("typematic_vld", ev_valid, 0);
    chk("typematic_key", key, 1);

    // Unmapped extended byte shares code 7
    send_frame(8'hE0, 0, 0);
    send_frame(8'h70, 0, 0);
    chk("other_key", key, 7);
    chk("other_held", held, 8'h9E);
    pop_chk("other_make", 4'hF);

`ifdef KBD_AUTOREPEAT_EN
    begin
      int seen;
      send_frame(8'h23, 0, 0);
      chk("rep_key", key, 6);
      pop_chk("rep_make", 4'hE);
      repeat (RDLY - 30) @(negedge clk);
      chk("rep_early", ev_valid, 0);
      seen = 0;
      for (int i = 0; i < 60 && seen == 0; i++) begin
        @(negedge clk);
        if (ev_valid) seen = 1;
      end
      chk("rep_first_seen", seen, 1);
      pop_chk("rep_first", 4'hE);
      repeat (RPER - 30) @(negedge clk);
      chk("rep_period_early", ev_valid, 0);
      seen = 0;
      for (int i = 0; i < 60 && seen == 0; i++) begin
        @(negedge clk);
        if (ev_valid) seen = 1;
      end
      chk("rep_period_seen", seen, 1);
      pop_chk("rep_second", 4'hE);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
